// File: rtl/can_tx_sched_pkg.sv
// Shared types and command-register decode constants for the CAN transmit scheduler.
package can_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        XMIT = 2'd2
    } tx_sched_state_e;

    localparam logic [7:0] CMD_ADDR    = 8'd1;
    localparam int         CMD_TR_BIT  = 0;
    localparam int         CMD_AT_BIT  = 1;
    localparam int         CMD_SRR_BIT = 4;

endpackage

// File: rtl/can_tx_retry_counter.sv
// Failed-attempt counter for the transmit scheduler; only built with CAN_TX_RETRY_LIMIT_EN.
module can_tx_retry_counter
    import can_tx_sched_pkg::*;
#(
    parameter int RETRY_MAX = 16,
    parameter int RETRY_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               incr,
    output logic [RETRY_W-1:0] count,
    output logic               at_limit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    // The attempt that would push the count to RETRY_MAX is turned into an abort.
    assign at_limit = (count == RETRY_W'(RETRY_MAX - 1));

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit-request controller: command decode, TBS/TCS/TS flags and BSP handshake.
// Optional retry limit is enabled by defining CAN_TX_RETRY_LIMIT_EN.
module can_tx_scheduler
    import can_tx_sched_pkg::*;
#(
    parameter int RETRY_MAX = 16,
    parameter int RETRY_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in,
    input  logic        reset_mode,
    input  logic        bus_off,
    input  logic        bsp_tx_start,
    input  logic        bsp_tx_done,
    input  logic        bsp_arb_lost,
    input  logic        bsp_tx_error,
    output logic        tx_request,
    output logic        single_shot,
    output logic        self_rx,
    output logic        transmit_buffer_status,
    output logic        transmission_complete,
    output logic        transmit_status,
    output logic        tx_irq,
    output logic        retry_exhausted
);

    tx_sched_state_e state, state_nxt;
    logic cmd_tr, cmd_at, cmd_srr, cmd_wr;
    logic abort_pend, abort_nxt, ss_nxt, srx_nxt, tcs_nxt, irq_nxt, exh_nxt;
    logic cnt_clr, cnt_inc, at_limit;
    logic req_d, tbs_d, ts_d;

    assign cmd_wr  = we && (addr == CMD_ADDR);
    assign cmd_tr  = cmd_wr && data_in[CMD_TR_BIT];
    assign cmd_at  = cmd_wr && data_in[CMD_AT_BIT];
    assign cmd_srr = cmd_wr && data_in[CMD_SRR_BIT];

    logic unused_data;
    assign unused_data = ^{data_in[31:5], data_in[3:2]};

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic [RETRY_W-1:0] retry_cnt;

    can_tx_retry_counter #(
        .RETRY_MAX(RETRY_MAX),
        .RETRY_W  (RETRY_W)
    ) u_retry (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clr),
        .incr    (cnt_inc),
        .count   (retry_cnt),
        .at_limit(at_limit)
    );
`else
    logic                unused_cnt;
    logic [RETRY_W-1:0]  unused_retry_cfg;
    assign at_limit         = 1'b0;
    assign unused_cnt       = cnt_clr ^ cnt_inc;
    assign unused_retry_cfg = RETRY_W'(RETRY_MAX);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcs_nxt   = transmission_complete;
        abort_nxt = abort_pend;
        ss_nxt    = single_shot;
        srx_nxt   = self_rx;
        exh_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (reset_mode) begin
            state_nxt = IDLE;
            tcs_nxt   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((cmd_tr || cmd_srr) && !bus_off) begin
                        state_nxt = PEND;
                        tcs_nxt   = 1'b0;
                        cnt_clr   = 1'b1;
                        ss_nxt    = cmd_at;
                        srx_nxt   = cmd_srr;
                    end
                end
                PEND: begin
                    if (bus_off) begin
                        state_nxt = IDLE;
                        tcs_nxt   = 1'b0;
                    end else if (bsp_tx_start) begin
                        state_nxt = XMIT;
                    end else if (cmd_at) begin
                        state_nxt = IDLE;
                        tcs_nxt   = 1'b0;
                    end
                end
                XMIT: begin
                    if (bus_off) begin
                        state_nxt = IDLE;
                        tcs_nxt   = 1'b0;
                    end else if (bsp_tx_done) begin
                        state_nxt = IDLE;
                        tcs_nxt   = 1'b1;
                    end else if (bsp_arb_lost || bsp_tx_error) begin
                        if (single_shot || abort_pend || at_limit) begin
                            state_nxt = IDLE;
                            tcs_nxt   = 1'b0;
                            exh_nxt   = at_limit && !single_shot && !abort_pend;
                        end else begin
                            state_nxt = PEND;
                            cnt_inc   = 1'b1;
                        end
                    end else if (cmd_at) begin
                        // The frame already on the bus is finished; the abort only blocks a retry.
                        abort_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (state_nxt == IDLE) begin
            abort_nxt = 1'b0;
            ss_nxt    = 1'b0;
            srx_nxt   = 1'b0;
        end
        irq_nxt = (state != IDLE) && (state_nxt == IDLE) && !reset_mode;
    end

    always_comb begin
        req_d = (state_nxt != IDLE);
        tbs_d = (state_nxt == IDLE);
        ts_d  = (state_nxt == XMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_request             <= 1'b0;
            transmit_buffer_status <= 1'b1;
            transmit_status        <= 1'b0;
            transmission_complete  <= 1'b1;
            single_shot            <= 1'b0;
            self_rx                <= 1'b0;
            abort_pend             <= 1'b0;
            tx_irq                 <= 1'b0;
            retry_exhausted        <= 1'b0;
        end else begin
            tx_request             <= req_d;
            transmit_buffer_status <= tbs_d;
            transmit_status        <= ts_d;
            transmission_complete  <= tcs_nxt;
            single_shot            <= ss_nxt;
            self_rx                <= srx_nxt;
            abort_pend             <= abort_nxt;
            tx_irq                 <= irq_nxt;
            retry_exhausted        <= exh_nxt;
        end
    end

endmodule
